action_mmio_queue: RTL and testbench
====================================

# action_mmio_queue

Memory-mapped action queue on the PicoRV32-style native bus, successor to the single-register action MMIO. The CPU assembles an action of `ACTION_W` bits in staging words, commits it into a `DEPTH`-entry FIFO, and the block drains entries to the packet datapath over a valid/ready stream. It also provides:
- a packet-start pulse,
- an accepted-action counter with readback of the last accepted action,
- overflow status and a drain-complete interrupt.

## Interface
- `ACTION_W`, 64: action width; a multiple of 32 in the range 32..256; NW = ACTION_W/32 words.
- `DEPTH`, 8: FIFO depth; a power of 2, minimum 2.
- `BASE_ADDR`, 32'h0301_0000: base of the 256-byte register window.

Clock and reset: reset `resetn`, asynchronous, active-low; clock `clk`.

Ports:
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `mem_valid`  in  1  bus request
- `mem_ready`  out  1  asserted combinationally when the access hits the window
- `mem_addr`  in  32  byte address
- `mem_wdata`  in  32  write data
- `mem_wstrb`  in  4  byte strobes; 0 means read
- `mem_rdata`  out  32  read data, combinational; 0 when not reading the window
- `act_valid`  out  1  head entry available
- `act_data`  out  ACTION_W  head entry
- `act_ready`  in  1  consumer accepts the head entry
- `pkt_start`  out  1  one-cycle packet-start pulse
- `irq`  out  1  level interrupt

## Operation
- Window select: sel = mem_valid and BASE_ADDR ≤ mem_addr < BASE_ADDR+0x100; offset = mem_addr[7:0]. A write is sel with |mem_wstrb; a read is sel with mem_wstrb == 0. Single-cycle access, no wait states.
- Register map. Unmapped offsets and words i ≥ NW read 0 and ignore writes.
  - 0x00+4i STAGE[i], RW: byte strobes honoured per byte.
  - 0x40 PUSH, WO: wdata[0]=1 with wstrb[0] set copies STAGE into the FIFO tail. If the FIFO is full, the push is dropped and OVF is set (sticky).
  - 0x44 PKT, WO: wdata[0]=1 produces a `pkt_start` pulse.
  - 0x48 STATUS, RO: bit0 empty, bit1 full, bit2 OVF, bit3 DONE_PEND, [23:8] count.
  - 0x4C CTRL, RW: bit0 EN (gates draining), bit1 IRQ_EN.
  - 0x50 CMD, WO, pulse bits: bit0 FLUSH, bit1 clear OVF, bit2 clear DONE_PEND.
  - 0x54 DONE_CNT, RO: 32-bit count of accepted transfers; wraps 0xFFFF_FFFF→0.
  - 0x60+4i LAST[i], RO: the last accepted action.
- FIFO:
  - `act_valid` = EN and not empty; `act_data` = head entry.
  - Transfer occurs when `act_valid` and `act_ready` are both high: head advances, DONE_CNT increments, LAST captures the head.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count is unchanged. A push while full is accepted if a pop occurs in the same cycle.
- FLUSH: pointers and count go to 0 at the next edge; stored data is don't-care. A transfer in the same cycle still updates DONE_CNT and LAST, but flush wins for pointers.
- DONE_PEND is set when a transfer leaves the FIFO empty (count 1→0 with no simultaneous push). Clear DONE_PEND takes priority over a same-cycle set. `irq` = IRQ_EN and DONE_PEND.
- Clearing EN while the FIFO is non-empty holds the entries and drops `act_valid` next cycle.

## Timing
- Reset (async): STAGE, CTRL, FIFO, OVF, DONE_PEND, DONE_CNT and LAST all 0. Outputs: `act_valid`=0, `pkt_start`=0, `irq`=0, `mem_rdata`=0, `act_data`=0.
- Register writes take effect at the clock edge of the access. Reads return pre-edge state.
- Push latency: for a push at edge k into an empty FIFO with EN=1, `act_valid`=1 during cycle k+1.
- Throughput: at most one transfer per cycle. Sustained back-to-back transfers are supported while `act_ready` is held high.
- `pkt_start` is high for exactly the one cycle after the PKT write edge. Consecutive writes produce consecutive pulses.
- STATUS count, full and empty reflect registered state after the edge.
- Reset mid-transfer: all state is discarded immediately. No transfer is counted for the cycle in which reset is asserted.

## Test plan
- Reset: assert `resetn`=0 mid-traffic → all outputs 0; STATUS reads 0x0000_0001 (empty).
- Single action, ACTION_W=64: write STAGE0=0x1111_2222, STAGE1=0x3333_4444, CTRL=0x1, PUSH=1 with `act_ready`=1 → `act_data`=0x3333_4444_1111_2222 for exactly one cycle; DONE_CNT=1; LAST0/LAST1 match.
- Fill and overflow, DEPTH=8, EN=0: 9 pushes → STATUS=0x0000_0806 (count 8, full, OVF). Set EN=1 → 8 entries drain in order. Write CMD=0x2 → OVF clears.
- Full plus simultaneous push/pop: FIFO full with `act_ready`=1 and a push in the same cycle → count stays 8 and OVF stays 0.
- Interrupt: CTRL=0x3, push 2 entries, drain both → `irq`=1 after the second transfer. Write CMD=0x4 → `irq`=0 next cycle.
- Byte strobes and flush:
  - Write STAGE0 with wstrb=0x2, wdata=0xAABB_CCDD → STAGE0=0x0000_CC00.
  - Push 3 entries, then FLUSH → count 0 and `act_valid`=0; DONE_CNT unchanged.

Source files
------------

// File: rtl/action_mmio_queue.sv
// Memory-mapped action queue: CPU stages ACTION_W-bit actions, commits them into a DEPTH-entry FIFO,
// and the FIFO drains to the packet datapath over valid/ready. Bus accesses complete in a single cycle.
module action_mmio_queue #(
  parameter int          ACTION_W  = 64,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0301_0000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_rdata,
  output logic                act_valid,
  output logic [ACTION_W-1:0] act_data,
  input  logic                act_ready,
  output logic                pkt_start,
  output logic                irq
);
  localparam int NW = ACTION_W / 32;
  localparam int AW = $clog2(DEPTH);

  logic [NW-1:0][31:0]   stage_q, stage_d;
  logic [ACTION_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  ovf_q, ovf_d, dpend_q, dpend_d;
  logic                  en_q, en_d, irq_en_q, irq_en_d, pkt_q, pkt_d;
  logic [31:0]           done_cnt_q, done_cnt_d;
  logic [NW-1:0][31:0]   last_q, last_d;

  logic       sel, wr, rd, empty, full, pop, push_req, push_ok, flush;
  logic [5:0] widx;
  logic [2:0] sub;

  // 33-bit compare so a window at the very top of the address space does not wrap
  assign sel       = mem_valid && (mem_addr >= BASE_ADDR) &&
                     ({1'b0, mem_addr} < ({1'b0, BASE_ADDR} + 33'h100));
  assign wr        = sel && (|mem_wstrb);
  assign rd        = sel && (mem_wstrb == 4'h0);
  assign widx      = mem_addr[7:2];
  assign sub       = mem_addr[4:2];
  assign mem_ready = sel;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign act_valid = en_q && !empty;
  assign act_data  = mem_q[rptr_q];
  assign pop       = act_valid && act_ready;
  assign push_req  = wr && (widx == 6'h10) && mem_wstrb[0] && mem_wdata[0];
  assign push_ok   = push_req && (!full || pop);
  assign flush     = wr && (widx == 6'h14) && mem_wdata[0];
  assign pkt_start = pkt_q;
  assign irq       = irq_en_q && dpend_q;

  always_comb begin
    stage_d    = stage_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    dpend_d    = dpend_q;
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    pkt_d      = 1'b0;
    done_cnt_d = done_cnt_q;
    last_d     = last_q;

    if (wr && (widx[5:3] == 3'b000)) begin
      for (int i = 0; i < NW; i++) begin
        if (sub == i[2:0]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) stage_d[i][8*b +: 8] = mem_wdata[8*b +: 8];
          end
        end
      end
    end
    if (wr && (widx == 6'h11)) pkt_d = mem_wdata[0];
    if (wr && (widx == 6'h13)) begin
      en_d     = mem_wdata[0];
      irq_en_d = mem_wdata[1];
    end

    if (push_req && !push_ok) ovf_d = 1'b1;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d     = rptr_q + 1'b1;
      done_cnt_d = done_cnt_q + 32'd1;
      last_d     = mem_q[rptr_q];
    end
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push_ok) cnt_d = cnt_q - 1'b1;

    if (pop && !push_ok && (cnt_q == (AW+1)'(1))) dpend_d = 1'b1;

    // Flush overrides pointer motion; DONE_CNT and LAST already took any same-cycle transfer
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
    if (wr && (widx == 6'h14) && mem_wdata[1]) ovf_d   = 1'b0;
    if (wr && (widx == 6'h14) && mem_wdata[2]) dpend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      dpend_q    <= 1'b0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pkt_q      <= 1'b0;
      done_cnt_q <= '0;
      last_q     <= '0;
    end else begin
      stage_q    <= stage_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      dpend_q    <= dpend_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      pkt_q      <= pkt_d;
      done_cnt_q <= done_cnt_d;
      last_q     <= last_d;
    end
  end

  // Storage is cleared on reset so act_data idles at zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wptr_q] <= stage_q;
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (rd) begin
      if (widx[5:3] == 3'b000) begin
        for (int i = 0; i < NW; i++) begin
          if (sub == i[2:0]) mem_rdata = stage_q[i];
        end
      end else if (widx[5:3] == 3'b011) begin
        for (int i = 0; i < NW; i++) begin
          if (sub == i[2:0]) mem_rdata = last_q[i];
        end
      end else begin
        case (widx)
          6'h12:   mem_rdata = {8'h00, 16'(cnt_q), 4'h0, dpend_q, ovf_q, full, empty};
          6'h13:   mem_rdata = {30'd0, irq_en_q, en_q};
          6'h15:   mem_rdata = done_cnt_q;
          default: mem_rdata = '0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_action_mmio_queue.sv
// Scoreboard bench for action_mmio_queue: staged actions are queued when pushed and
// compared against act_data whenever a transfer is observed.
module tb_action_mmio_queue;
  localparam logic [31:0] BASE = 32'h0301_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        act_valid;
  logic [63:0] act_data;
  logic        act_ready = 1'b0;
  logic        pkt_start;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];
  logic [31:0] rv;

  action_mmio_queue #(.ACTION_W(64), .DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .pkt_start(pkt_start), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transfers are judged on the falling edge, before the rising edge that commits them
  always @(negedge clk) begin
    if (resetn && act_valid && act_ready) begin
      if (sb.size() == 0) check("unexpected_transfer", act_data, 64'hX);
      else check("act_data", act_data, sb.pop_front());
    end
  end

  task automatic bus_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = BASE + 32'(off); mem_wdata = d; mem_wstrb = s;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
  endtask

  task automatic bus_rd(input logic [7:0] off, output logic [31:0] d);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = BASE + 32'(off); mem_wstrb = 4'h0;
    #1 d = mem_rdata;
    @(posedge clk); #1;
    mem_valid = 1'b0;
  endtask

  task automatic stage(input logic [63:0] v);
    bus_wr(8'h00, v[31:0]);
    bus_wr(8'h04, v[63:32]);
  endtask

  task automatic push_action(input logic [63:0] v, input bit accepted);
    stage(v);
    if (accepted) sb.push_back(v);
    bus_wr(8'h40, 32'h1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain_done", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Reset state
    check("rst_act_valid", 64'(act_valid), 64'd0);
    check("rst_act_data", act_data, 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    bus_rd(8'h48, rv); check("rst_status", 64'(rv), 64'h1);
    bus_rd(8'h54, rv); check("rst_done_cnt", 64'(rv), 64'h0);

    // Byte strobes, unmapped offsets and words beyond the action width
    bus_wr(8'h00, 32'hAABB_CCDD, 4'h2);
    bus_rd(8'h00, rv); check("stage_strobe", 64'(rv), 64'h0000_CC00);
    bus_wr(8'h08, 32'hDEAD_BEEF);
    bus_rd(8'h08, rv); check("stage_oob", 64'(rv), 64'h0);
    bus_rd(8'h5C, rv); check("unmapped", 64'(rv), 64'h0);

    // Packet-start pulses
    bus_wr(8'h44, 32'h1);
    check("pkt_pulse", 64'(pkt_start), 64'd1);
    bus_wr(8'h44, 32'h1);
    check("pkt_pulse2", 64'(pkt_start), 64'd1);
    @(posedge clk); #1 check("pkt_end", 64'(pkt_start), 64'd0);

    // Single action
    act_ready = 1'b1;
    stage(64'h3333_4444_1111_2222);
    bus_wr(8'h4C, 32'h1);
    sb.push_back(64'h3333_4444_1111_2222);
    bus_wr(8'h40, 32'h1);
    check("single_vld", 64'(act_valid), 64'd1);
    check("single_data", act_data, 64'h3333_4444_1111_2222);
    @(posedge clk); #1 check("single_vld_drop", 64'(act_valid), 64'd0);
    bus_rd(8'h54, rv); check("single_done_cnt", 64'(rv), 64'd1);
    bus_rd(8'h60, rv); check("last0", 64'(rv), 64'h1111_2222);
    bus_rd(8'h64, rv); check("last1", 64'(rv), 64'h3333_4444);
    bus_rd(8'h48, rv); check("single_status", 64'(rv), 64'h9);

    // Fill and overflow with draining disabled
    bus_wr(8'h50, 32'h4);
    bus_wr(8'h4C, 32'h0);
    for (int i = 0; i < 9; i++) push_action({32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)}, i < 8);
    bus_rd(8'h48, rv); check("ovf_status", 64'(rv), 64'h806);
    check("ovf_no_vld", 64'(act_valid), 64'd0);
    bus_wr(8'h4C, 32'h1);
    wait_drain();
    bus_rd(8'h54, rv); check("ovf_done_cnt", 64'(rv), 64'd9);
    bus_wr(8'h50, 32'h2);
    bus_rd(8'h48, rv); check("ovf_cleared", 64'(rv), 64'h9);
    bus_wr(8'h50, 32'h4);

    // Push into a full FIFO in the same cycle as a pop
    act_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_action({32'hB000_0000 + 32'(i), 32'h6000_0000 + 32'(i)}, 1'b1);
    stage(64'hC0DE_0009_C0DE_0009);
    @(posedge clk); #1 act_ready = 1'b1;
    sb.push_back(64'hC0DE_0009_C0DE_0009);
    bus_wr(8'h40, 32'h1);
    act_ready = 1'b0;
    bus_rd(8'h48, rv); check("full_pushpop_status", 64'(rv), 64'h802);
    act_ready = 1'b1;
    wait_drain();
    bus_rd(8'h54, rv); check("full_done_cnt", 64'(rv), 64'd18);

    // Drain-complete interrupt
    bus_wr(8'h50, 32'h4);
    bus_wr(8'h4C, 32'h3);
    check("irq_idle", 64'(irq), 64'd0);
    push_action(64'h0000_0001_0000_00A1, 1'b1);
    push_action(64'h0000_0002_0000_00A2, 1'b1);
    wait_drain();
    @(posedge clk); #1 check("irq_set", 64'(irq), 64'd1);
    bus_wr(8'h50, 32'h4);
    check("irq_clr", 64'(irq), 64'd0);

    // Flush
    bus_wr(8'h4C, 32'h0);
    for (int i = 0; i < 3; i++) push_action({32'hF000_0000, 32'(i)}, 1'b0);
    bus_rd(8'h48, rv); check("pre_flush_status", 64'(rv), 64'h300);
    bus_wr(8'h50, 32'h1);
    bus_rd(8'h48, rv); check("flush_status", 64'(rv), 64'h1);
    bus_wr(8'h4C, 32'h1);
    @(posedge clk); #1 check("flush_no_vld", 64'(act_valid), 64'd0);
    bus_rd(8'h54, rv); check("flush_done_cnt", 64'(rv), 64'd20);

    // Reset in the middle of traffic
    act_ready = 1'b0;
    push_action(64'h1234_5678_9ABC_DEF0, 1'b0);
    push_action(64'h0FED_CBA9_8765_4321, 1'b0);
    check("pre_rst_vld", 64'(act_valid), 64'd1);
    act_ready = 1'b1;
    @(negedge clk) resetn = 1'b0;
    #1;
    check("midrst_act_valid", 64'(act_valid), 64'd0);
    check("midrst_act_data", act_data, 64'd0);
    check("midrst_pkt", 64'(pkt_start), 64'd0);
    check("midrst_irq", 64'(irq), 64'd0);
    @(negedge clk) resetn = 1'b1;
    bus_rd(8'h48, rv); check("midrst_status", 64'(rv), 64'h1);
    bus_rd(8'h54, rv); check("midrst_done_cnt", 64'(rv), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
